// File: rtl/serial_frame_receiver_if.sv
// serial_frame_receiver_if: serial input, bit strobe, parallel word handshake
// and status flags of the serial frame receiver.
//  master : the producer/consumer side (drives sin, en, ack)
//  slave  : the receiver itself
interface serial_frame_receiver_if #(
    parameter int WIDTH  = 8,
    parameter int FCNT_W = 8
);
    logic              sin;
    logic              en;
    logic              ack;
    logic [WIDTH-1:0]  data_out;
    logic              valid;
    logic              frame_err;
    logic              overrun;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output sin, en, ack,
        input  data_out, valid, frame_err, overrun, frame_cnt
    );

    modport slave (
        input  sin, en, ack,
        output data_out, valid, frame_err, overrun, frame_cnt
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: frames a strobed serial stream as
//   start(1), WIDTH data bits MSB first, [even parity bit], stop(0)
// and presents accepted words on a valid/ack handshake with an
// accepted-frame counter and a sticky overrun flag.
// Optional feature macro: SFR_PARITY_EN (adds the even-parity bit).
module serial_frame_receiver #(
    parameter int WIDTH  = 8,
    parameter int FCNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    serial_frame_receiver_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SFR_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;
`endif

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                frame_ok;
`ifdef SFR_PARITY_EN
    logic                par_q, par_d;
`endif

    // Frame is good when the stop bit is 0 (and, with parity, the even-parity check holds).
`ifdef SFR_PARITY_EN
    assign frame_ok = !bus.sin && ((^shreg_q ^ par_q) == 1'b0);
`else
    assign frame_ok = !bus.sin;
`endif

    // State and datapath registers; async reset discards any partial frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            fcnt_q   <= '0;
`ifdef SFR_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
            fcnt_q   <= fcnt_d;
`ifdef SFR_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Next-state logic; the FSM only moves on bit-strobe cycles.
    always_comb begin
        state_d = state_q;
        if (bus.en) begin
            case (state_q)
                S_IDLE:   if (bus.sin) state_d = S_DATA;
                S_DATA: begin
                    if (bitcnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SFR_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef SFR_PARITY_EN
                S_PARITY: state_d = S_STOP;
`endif
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath/output next values: shifting, stop-bit decision and handshake.
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = ovr_q;
        fcnt_d   = fcnt_q;
`ifdef SFR_PARITY_EN
        par_d    = par_q;
`endif
        // Consumer takes the word; a same-cycle accept below may reload it.
        if (valid_q && bus.ack) begin
            valid_d = 1'b0;
        end
        if (bus.en) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.sin) bitcnt_d = '0;
                end
                S_DATA: begin
                    shreg_d  = {shreg_q[WIDTH-2:0], bus.sin};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                end
`ifdef SFR_PARITY_EN
                S_PARITY: begin
                    par_d = bus.sin;
                end
`endif
                S_STOP: begin
                    if (frame_ok) begin
                        if (!valid_q || bus.ack) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                            fcnt_d  = fcnt_q + FCNT_W'(1);
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.frame_cnt = fcnt_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: random frames with random en gaps, ack pulses and
// bad frames, compared against a word-level model of the receiver.
module tb_serial_frame_receiver;
    localparam int WIDTH  = 8;
    localparam int FCNT_W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    // reference model state
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;
    logic [7:0] m_cnt;

    serial_frame_receiver_if #(.WIDTH(WIDTH), .FCNT_W(FCNT_W)) bus ();

    serial_frame_receiver #(.WIDTH(WIDTH), .FCNT_W(FCNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic exp_ferr);
        check({tag, ".data"},  32'(bus.data_out),  32'(m_data));
        check({tag, ".valid"}, 32'(bus.valid),     32'(m_valid));
        check({tag, ".cnt"},   32'(bus.frame_cnt), 32'(m_cnt));
        check({tag, ".ovr"},   32'(bus.overrun),   32'(m_ovr));
        check({tag, ".ferr"},  32'(bus.frame_err), 32'(exp_ferr));
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_cnt   = '0;
    endtask

    // one strobed bit, optionally preceded by en=0 cycles carrying junk on sin
    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.en  = 1'b0;
                bus.sin = 1'($urandom);
                tick();
            end
        end
        bus.en  = 1'b1;
        bus.sin = b;
        tick();
    endtask

    // full frame; after it returns the stop bit has just been sampled
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                              input bit ack_stop, input bit gaps);
        logic good;
        logic exp_ferr;
        send_bit(1'b1, gaps);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(d[i], gaps);
`ifdef SFR_PARITY_EN
        send_bit(par_bit, gaps);
        good = !stop_bit && ((^d ^ par_bit) == 1'b0);
`else
        good = !stop_bit;
`endif
        if (ack_stop) bus.ack = 1'b1;
        send_bit(stop_bit, gaps);
        bus.ack = 1'b0;
        // word-level expectation for this frame
        exp_ferr = !good;
        if (good) begin
            if (!m_valid || ack_stop) begin
                m_data  = d;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 8'd1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (ack_stop) begin
            m_valid = 1'b0;
        end
        $display("frame d=%02h stop=%0b par=%0b ack_stop=%0b good=%0b -> data=%02h valid=%0b cnt=%0d ovr=%0b ferr=%0b",
                 d, stop_bit, par_bit, ack_stop, good, bus.data_out, bus.valid, bus.frame_cnt,
                 bus.overrun, bus.frame_err);
        check_outputs("frame", exp_ferr);
        // frame_err must be a single-cycle pulse
        bus.en  = 1'b1;
        bus.sin = 1'b0;
        tick();
        check("ferr_pulse_end", 32'(bus.frame_err), 32'd0);
    endtask

    task automatic ack_pulse();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        m_valid = 1'b0;
        check("ack_clears_valid", 32'(bus.valid), 32'd0);
        check("ack_keeps_data",   32'(bus.data_out), 32'(m_data));
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    initial begin
        logic [7:0] d;
        logic       stop_bit;
        logic       par_bit;
        logic [7:0] cnt0;
        n_checks = 0;
        n_pass   = 0;
        bus.sin  = 1'b0;
        bus.en   = 1'b0;
        bus.ack  = 1'b0;
        model_reset();

        // reset held, then idle line
        rst = 1'b1;
        repeat (3) tick();
        check_outputs("reset", 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.en  = 1'b1;
            bus.sin = 1'b0;
            tick();
            check("idle_valid", 32'(bus.valid), 32'd0);
            check("idle_cnt",   32'(bus.frame_cnt), 32'd0);
        end

        // directed sequence
        send_frame(8'hA6, 1'b0, even_par(8'hA6), 1'b0, 1'b0);
        check("a6_data", 32'(bus.data_out), 32'h0000_00A6);
        send_frame(8'h3C, 1'b0, even_par(8'h3C), 1'b0, 1'b0);
        check("overrun_set", 32'(bus.overrun), 32'd1);
        ack_pulse();
        send_frame(8'h11, 1'b0, even_par(8'h11), 1'b0, 1'b1);
        send_frame(8'h5A, 1'b1, even_par(8'h5A), 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, even_par(8'hFF), 1'b1, 1'b0);
        check("ff_reload_valid", 32'(bus.valid), 32'd1);
`ifdef SFR_PARITY_EN
        ack_pulse();
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        ack_pulse();
        send_frame(8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // mid-frame asynchronous reset
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs("midreset", 1'b0);
        tick();
        rst = 1'b0;
        bus.en  = 1'b1;
        bus.sin = 1'b0;
        tick();
        send_frame(8'hC3, 1'b0, even_par(8'hC3), 1'b0, 1'b1);

        // randomized frames
        for (int n = 0; n < 60; n++) begin
            d        = 8'($urandom);
            stop_bit = 1'b0;
            par_bit  = even_par(d);
            if ($urandom_range(0, 5) == 0) begin
`ifdef SFR_PARITY_EN
                if ($urandom_range(0, 1) == 0) par_bit = ~par_bit;
                else stop_bit = 1'b1;
`else
                stop_bit = 1'b1;
`endif
            end
            send_frame(d, stop_bit, par_bit, ($urandom_range(0, 3) == 0), 1'b1);
            if ($urandom_range(0, 1) == 0) ack_pulse();
            repeat ($urandom_range(0, 2)) begin
                bus.en  = 1'($urandom);
                bus.sin = 1'b0;
                tick();
            end
        end

        // counter wrap: 256 frames all accepted via ack at the stop sample
        cnt0 = m_cnt;
        for (int n = 0; n < 256; n++) begin
            d = 8'($urandom);
            send_frame(d, 1'b0, even_par(d), 1'b1, 1'b0);
        end
        check("cnt_wrap", 32'(bus.frame_cnt), 32'(cnt0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
